// File: rtl/ultrasonic_echo_responder_pkg.sv
// Shared types and default timing constants for the ultrasonic echo responder.
// All times are in 1 us clock ticks.
package radar_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    TRIG    = 3'd1,
    BURST   = 3'd2,
    ECHO    = 3'd3,
    HOLDOFF = 3'd4
  } state_t;

  typedef logic [17:0] width_t;

  localparam int DEFAULT_TRIG_MIN_US = 10;
  localparam int DEFAULT_BURST_US    = 200;
  localparam int DEFAULT_CM_TO_US    = 58;
  localparam int DEFAULT_MAX_CM      = 400;
  localparam int DEFAULT_TIMEOUT_US  = 38000;
  localparam int DEFAULT_HOLDOFF_US  = 10000;

  // Zero or beyond-range distances report the out-of-range timeout width.
  function automatic width_t echo_width(input logic [10:0] d, input int cm_to_us,
                                        input int max_cm, input int timeout_us);
    if (d == '0 || int'(d) > max_cm) return width_t'(timeout_us);
    return width_t'(d) * width_t'(cm_to_us);
  endfunction

endpackage

// File: rtl/ultrasonic_echo_responder.sv
// Emulates an HC-SR04 style sensor: validates a trigger pulse, waits out the
// burst, then returns an echo whose width encodes the requested distance.
module ultrasonic_echo_responder
  import radar_pkg::*;
#(
  parameter int TRIG_MIN_US = DEFAULT_TRIG_MIN_US,
  parameter int BURST_US    = DEFAULT_BURST_US,
  parameter int CM_TO_US    = DEFAULT_CM_TO_US,
  parameter int MAX_CM      = DEFAULT_MAX_CM,
  parameter int TIMEOUT_US  = DEFAULT_TIMEOUT_US,
  parameter int HOLDOFF_US  = DEFAULT_HOLDOFF_US
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        trig,
  input  logic [10:0] distance_cm,
  output logic        echo,
  output logic        busy,
  output logic        short_trig,
  output logic [17:0] meas_width
);

  localparam width_t BURST_LOAD   = width_t'((BURST_US > 0) ? BURST_US - 1 : 0);
  localparam width_t HOLDOFF_LOAD = width_t'((HOLDOFF_US > 0) ? HOLDOFF_US - 1 : 0);

  state_t     state;
  logic       trig_q;
  logic [3:0] trig_cnt;
  width_t     timer;

  // The shared timer is loaded with (duration - 1) on entry so that each timed
  // state lasts exactly its duration and the exit happens when it reads zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      trig_q     <= 1'b0;
      trig_cnt   <= '0;
      timer      <= '0;
      echo       <= 1'b0;
      busy       <= 1'b0;
      short_trig <= 1'b0;
      meas_width <= '0;
    end else begin
      trig_q     <= trig;
      short_trig <= 1'b0;
      case (state)
        IDLE: begin
          if (trig && !trig_q) begin
            state    <= TRIG;
            trig_cnt <= 4'd1;
            busy     <= 1'b1;
          end
        end
        TRIG: begin
          if (trig) begin
            if (trig_cnt != 4'd15) trig_cnt <= trig_cnt + 4'd1;
          end else if (int'(trig_cnt) >= TRIG_MIN_US) begin
            state      <= BURST;
            trig_cnt   <= '0;
            timer      <= BURST_LOAD;
            meas_width <= echo_width(distance_cm, CM_TO_US, MAX_CM, TIMEOUT_US);
          end else begin
            state      <= IDLE;
            trig_cnt   <= '0;
            busy       <= 1'b0;
            short_trig <= 1'b1;
          end
        end
        BURST: begin
          if (timer == '0) begin
            state <= ECHO;
            echo  <= 1'b1;
            timer <= (meas_width == '0) ? '0 : meas_width - width_t'(1);
          end else begin
            timer <= timer - width_t'(1);
          end
        end
        ECHO: begin
          if (timer == '0) begin
            state <= HOLDOFF;
            echo  <= 1'b0;
            timer <= HOLDOFF_LOAD;
          end else begin
            timer <= timer - width_t'(1);
          end
        end
        HOLDOFF: begin
          if (timer == '0) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            timer <= timer - width_t'(1);
          end
        end
        default: begin
          state    <= IDLE;
          trig_cnt <= '0;
          timer    <= '0;
          echo     <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ultrasonic_echo_responder.sv
// Randomized self-checking bench for ultrasonic_echo_responder, run with
// shortened timing parameters so full timeout measurements stay cheap.
module tb_ultrasonic_echo_responder;
  import radar_pkg::*;

  localparam int TRIG_MIN = 10;
  localparam int BURST    = 20;
  localparam int CM2US    = 3;
  localparam int MAXCM    = 400;
  localparam int TIMEOUT  = 1500;
  localparam int HOLDOFF  = 50;
  localparam int LIMIT    = 5000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        trig = 1'b0;
  logic [10:0] distance_cm = '0;
  logic        echo;
  logic        busy;
  logic        short_trig;
  logic [17:0] meas_width;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  ultrasonic_echo_responder #(
    .TRIG_MIN_US(TRIG_MIN), .BURST_US(BURST), .CM_TO_US(CM2US),
    .MAX_CM(MAXCM), .TIMEOUT_US(TIMEOUT), .HOLDOFF_US(HOLDOFF)
  ) dut (
    .clk(clk), .rst_n(rst_n), .trig(trig), .distance_cm(distance_cm),
    .echo(echo), .busy(busy), .short_trig(short_trig), .meas_width(meas_width)
  );

  // Reference: in-range distances map linearly, everything else times out.
  function automatic int model_width(input int d);
    if (d >= 1 && d <= MAXCM) return d * CM2US;
    return TIMEOUT;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // trig high for len sampled edges, then one edge sampling trig low.
  task automatic fire_trig(input int len);
    trig = 1'b1;
    repeat (len) tick();
    trig = 1'b0;
    tick();
  endtask

  task automatic wait_echo_rise(output int n);
    n = 0;
    while (echo !== 1'b1 && n < LIMIT) begin tick(); n++; end
  endtask

  task automatic wait_echo_fall(output int n);
    n = 0;
    while (echo !== 1'b0 && n < LIMIT) begin tick(); n++; end
  endtask

  task automatic wait_busy_fall(output int n);
    n = 0;
    while (busy !== 1'b0 && n < LIMIT) begin tick(); n++; end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    trig  = 1'b0;
    repeat (2) tick();
    checks++; if (echo !== 1'b0) $display("[TB] FAIL reset_echo: got %b expected 0", echo); else passed++;
    checks++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", busy); else passed++;
    checks++; if (short_trig !== 1'b0) $display("[TB] FAIL reset_short: got %b expected 0", short_trig); else passed++;
    checks++; if (meas_width !== 18'd0) $display("[TB] FAIL reset_width: got %0d expected 0", meas_width); else passed++;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_measure(input string name, input int d, input int len);
    int n, exp_w;
    exp_w = model_width(d);
    distance_cm = 11'(d);
    fire_trig(len);
    checks++; if (busy !== 1'b1) $display("[TB] FAIL %s_busy: got %b expected 1", name, busy); else passed++;
    wait_echo_rise(n);
    checks++; if (n != BURST) $display("[TB] FAIL %s_burst: got %0d expected %0d", name, n, BURST); else passed++;
    checks++; if (meas_width !== 18'(exp_w)) $display("[TB] FAIL %s_meas: got %0d expected %0d", name, meas_width, exp_w); else passed++;
    wait_echo_fall(n);
    checks++; if (n != exp_w) $display("[TB] FAIL %s_echo: got %0d expected %0d", name, n, exp_w); else passed++;
    wait_busy_fall(n);
    checks++; if (n != HOLDOFF) $display("[TB] FAIL %s_hold: got %0d expected %0d", name, n, HOLDOFF); else passed++;
    checks++; if (meas_width !== 18'(exp_w)) $display("[TB] FAIL %s_last: got %0d expected %0d", name, meas_width, exp_w); else passed++;
    tick();
  endtask

  task automatic test_short_trig(input int len);
    int highs;
    distance_cm = 11'd100;
    fire_trig(len);
    checks++; if (short_trig !== 1'b1) $display("[TB] FAIL short_pulse(len=%0d): got %b expected 1", len, short_trig); else passed++;
    checks++; if (busy !== 1'b0) $display("[TB] FAIL short_busy(len=%0d): got %b expected 0", len, busy); else passed++;
    tick();
    checks++; if (short_trig !== 1'b0) $display("[TB] FAIL short_width(len=%0d): got %b expected 0", len, short_trig); else passed++;
    highs = 0;
    repeat (BURST + 20) begin tick(); if (echo === 1'b1) highs++; end
    checks++; if (highs != 0) $display("[TB] FAIL short_echo(len=%0d): got %0d expected 0", len, highs); else passed++;
  endtask

  task automatic test_boundaries();
    test_measure("d400", 400, 10);
    test_measure("d500", 500, 10);
    test_measure("d0", 0, 10);
    test_measure("d100_sat", 100, 25);
    test_short_trig(9);
    test_short_trig(1);
  endtask

  task automatic test_random();
    int d, sel;
    for (int i = 0; i < 8; i++) begin
      sel = $urandom_range(0, 5);
      case (sel)
        0: d = 0;
        1: d = 400;
        2: d = $urandom_range(401, 2047);
        default: d = $urandom_range(1, 399);
      endcase
      test_measure($sformatf("rnd%0d", i), d, $urandom_range(TRIG_MIN, 20));
      if ($urandom_range(0, 2) == 0) test_short_trig($urandom_range(1, TRIG_MIN - 1));
    end
  endtask

  task automatic test_distance_change();
    int n;
    distance_cm = 11'd100;
    fire_trig(10);
    distance_cm = 11'd300;
    wait_echo_rise(n);
    wait_echo_fall(n);
    checks++; if (n != 300) $display("[TB] FAIL dchg_echo: got %0d expected 300", n); else passed++;
    wait_busy_fall(n);
    tick();
  endtask

  task automatic test_trig_ignored();
    int n, k, highs, exp_w;
    distance_cm = 11'd200;
    exp_w = model_width(200);
    fire_trig(12);
    wait_echo_rise(n);
    k = 0;
    repeat (40) begin tick(); k++; end
    trig = 1'b1;
    repeat (12) begin tick(); k++; end
    trig = 1'b0;
    wait_echo_fall(n);
    checks++; if (k + n != exp_w) $display("[TB] FAIL midecho_width: got %0d expected %0d", k + n, exp_w); else passed++;
    trig = 1'b1;
    wait_busy_fall(n);
    checks++; if (n != HOLDOFF) $display("[TB] FAIL held_hold: got %0d expected %0d", n, HOLDOFF); else passed++;
    highs = 0;
    repeat (30) begin tick(); if (busy !== 1'b0) highs++; end
    checks++; if (highs != 0) $display("[TB] FAIL held_restart: got %0d expected 0", highs); else passed++;
    trig = 1'b0;
    tick();
    test_measure("after_held", 150, 10);
  endtask

  task automatic test_reset_mid_echo();
    int n, highs;
    distance_cm = 11'd300;
    fire_trig(10);
    wait_echo_rise(n);
    repeat (30) tick();
    rst_n = 1'b0;
    tick();
    checks++; if (echo !== 1'b0) $display("[TB] FAIL rstmid_echo: got %b expected 0", echo); else passed++;
    checks++; if (busy !== 1'b0) $display("[TB] FAIL rstmid_busy: got %b expected 0", busy); else passed++;
    rst_n = 1'b1;
    highs = 0;
    repeat (BURST + 50) begin tick(); if (echo !== 1'b0 || busy !== 1'b0) highs++; end
    checks++; if (highs != 0) $display("[TB] FAIL rstmid_resume: got %0d expected 0", highs); else passed++;
    test_measure("after_rst", 300, 10);
  endtask

  initial begin
    $display("[TB] starting ultrasonic_echo_responder bench");
    test_reset();
    test_measure("d100", 100, 10);
    test_boundaries();
    test_distance_change();
    test_trig_ignored();
    test_reset_mid_echo();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #(10 * 90000);
    $display("[TB] FAIL watchdog: simulation exceeded its cycle budget");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
